// File: rtl/dequantize.sv
// dequantize: expands signed 8-bit quantized activations to signed 16-bit
// fixed point. out = sat16(round(in * scale / 2^SHIFT) + bias), over a
// two-stage pipeline with valid/ready handshakes on both sides.
module dequantize #(
    parameter int SHIFT = 7,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [15:0]        cfg_scale,
    input  logic [15:0]        cfg_bias,
    input  logic               Data_in_valid,
    output logic               Data_in_ready,
    input  logic [7:0]         Data_in,
    output logic               Data_out_valid,
    input  logic               Data_out_ready,
    output logic [15:0]        Data_out,
    output logic               sat_flag,
    output logic [CNT_W-1:0]   sample_count
);

    localparam logic signed [25:0] MAX_V = 26'sd32767;
    localparam logic signed [25:0] MIN_V = -26'sd32768;

    // Round-half-up term; no rounding when the product is not shifted.
    localparam logic signed [25:0] RND = (SHIFT > 0) ? (26'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 26'sd0;

    logic [15:0]        scale_q, scale_d;
    logic [15:0]        bias_q, bias_d;
    logic               s1_valid_q, s1_valid_d;
    logic [23:0]        s1_prod_q, s1_prod_d;
    logic [15:0]        s1_bias_q, s1_bias_d;
    logic               out_valid_q, out_valid_d;
    logic [15:0]        out_data_q, out_data_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               en1, en2;
    logic               in_xfer, out_xfer;
    logic [23:0]        din_ext, scale_ext;
    logic signed [25:0] prod_ext, rounded, shifted, bias_ext, sum;

    // Stall chain: stage 2 advances when empty or drained, stage 1 when
    // empty or stage 2 advances, so a full pipe still streams every cycle.
    always_comb begin
        en2      = !out_valid_q || Data_out_ready;
        en1      = !s1_valid_q || en2;
        in_xfer  = Data_in_valid && en1;
        out_xfer = out_valid_q && Data_out_ready;
    end

    // Stage-1 product and stage-2 round/shift/bias/clamp datapath.
    always_comb begin
        din_ext   = {{16{Data_in[7]}}, Data_in};
        scale_ext = {{8{scale_q[15]}}, scale_q};
        prod_ext  = {{2{s1_prod_q[23]}}, s1_prod_q};
        rounded   = prod_ext + RND;
        shifted   = rounded >>> SHIFT;
        bias_ext  = {{10{s1_bias_q[15]}}, s1_bias_q};
        sum       = shifted + bias_ext;
    end

    // Next-state for config, both pipeline stages and the output counter.
    always_comb begin
        scale_d     = cfg_load ? cfg_scale : scale_q;
        bias_d      = cfg_load ? cfg_bias : bias_q;

        s1_valid_d  = s1_valid_q;
        s1_prod_d   = s1_prod_q;
        s1_bias_d   = s1_bias_q;
        if (en1) begin
            s1_valid_d = in_xfer;
            if (in_xfer) begin
                // Config is captured with the sample, so later loads do not
                // disturb anything already in flight.
                s1_prod_d = din_ext * scale_ext;
                s1_bias_d = bias_q;
            end
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;
        if (en2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (sum > MAX_V) begin
                    out_data_d = 16'h7FFF;
                    sat_d      = 1'b1;
                end else if (sum < MIN_V) begin
                    out_data_d = 16'h8000;
                    sat_d      = 1'b1;
                end else begin
                    out_data_d = sum[15:0];
                    sat_d      = 1'b0;
                end
            end
        end

        cnt_d = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            scale_q     <= 16'h0001 << SHIFT;
            bias_q      <= 16'h0000;
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= 24'h0;
            s1_bias_q   <= 16'h0000;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            scale_q     <= scale_d;
            bias_q      <= bias_d;
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_bias_q   <= s1_bias_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Data_in_ready  = en1;
    assign Data_out_valid = out_valid_q;
    assign Data_out       = out_data_q;
    assign sat_flag       = sat_q;
    assign sample_count   = cnt_q;

endmodule

// File: tb/tb_dequantize.sv
// Directed testbench for dequantize with hand-computed expected values.
module tb_dequantize;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [15:0] cfg_scale;
    logic [15:0] cfg_bias;
    logic        Data_in_valid;
    logic        Data_in_ready;
    logic [7:0]  Data_in;
    logic        Data_out_valid;
    logic        Data_out_ready;
    logic [15:0] Data_out;
    logic        sat_flag;
    logic [15:0] sample_count;

    int errors = 0;
    int checks = 0;

    dequantize #(.SHIFT(7), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_load       (cfg_load),
        .cfg_scale      (cfg_scale),
        .cfg_bias       (cfg_bias),
        .Data_in_valid  (Data_in_valid),
        .Data_in_ready  (Data_in_ready),
        .Data_in        (Data_in),
        .Data_out_valid (Data_out_valid),
        .Data_out_ready (Data_out_ready),
        .Data_out       (Data_out),
        .sat_flag       (sat_flag),
        .sample_count   (sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [15:0] s, input logic [15:0] b);
        cfg_load  = 1'b1;
        cfg_scale = s;
        cfg_bias  = b;
        step();
        cfg_load  = 1'b0;
    endtask

    // One isolated sample with the output side always ready.
    task automatic send_check(input string tag, input logic [7:0] din,
                              input logic [15:0] exp, input logic exp_sat);
        Data_in_valid = 1'b1;
        Data_in       = din;
        step();
        Data_in_valid = 1'b0;
        step();
        check({tag, "_valid"}, {31'd0, Data_out_valid}, 32'd1);
        check(tag, {16'd0, Data_out}, {16'd0, exp});
        check({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, exp_sat});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] bp_in  [4];
        int idx, oidx, first_cyc, last_cyc;
        logic acc;

        rst = 1'b1; cfg_load = 1'b0; cfg_scale = '0; cfg_bias = '0;
        Data_in_valid = 1'b0; Data_in = '0; Data_out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {31'd0, Data_out_valid}, 32'd0);
        check("rst_data_out", {16'd0, Data_out}, 32'd0);
        check("rst_sat", {31'd0, sat_flag}, 32'd0);
        check("rst_count", {16'd0, sample_count}, 32'd0);
        check("rst_in_ready", {31'd0, Data_in_ready}, 32'd1);

        // Identity: back-to-back 8'h80, 8'h7F
        Data_in_valid = 1'b1; Data_in = 8'h80;
        step();
        Data_in = 8'h7F;
        step();
        Data_in_valid = 1'b0;
        check("id_first", {16'd0, Data_out}, 32'h0000FF80);
        check("id_first_valid", {31'd0, Data_out_valid}, 32'd1);
        step();
        check("id_second", {16'd0, Data_out}, 32'h0000007F);
        check("id_second_sat", {31'd0, sat_flag}, 32'd0);
        step();
        check("id_count", {16'd0, sample_count}, 32'd2);
        check("id_drained", {31'd0, Data_out_valid}, 32'd0);

        // Scale 2.0, bias 16: 127*256 -> 254, +16 = 270
        load_cfg(16'h0100, 16'h0010);
        send_check("scale2", 8'h7F, 16'h010E, 1'b0);

        // Rounding at scale 0.5
        load_cfg(16'h0040, 16'h0000);
        send_check("rnd_p3", 8'h03, 16'h0002, 1'b0);
        send_check("rnd_m3", 8'hFD, 16'hFFFF, 1'b0);
        send_check("rnd_p1", 8'h01, 16'h0001, 1'b0);

        // Saturation
        load_cfg(16'h7FFF, 16'h1000);
        send_check("sat_pos", 8'h7F, 16'h7FFF, 1'b1);
        load_cfg(16'h7FFF, 16'h8000);
        send_check("sat_neg", 8'h80, 16'h8000, 1'b1);

        // Exact boundaries: reach the limits without clamping
        load_cfg(16'h0080, 16'h7F80);
        send_check("edge_max", 8'h7F, 16'h7FFF, 1'b0);
        load_cfg(16'h0080, 16'h8080);
        send_check("edge_min", 8'h80, 16'h8000, 1'b0);

        // Backpressure: 4 samples, output stalled for 5 cycles
        load_cfg(16'h0080, 16'h0000);
        bp_in[0] = 16'd1; bp_in[1] = 16'd2; bp_in[2] = 16'd3; bp_in[3] = 16'd4;
        idx = 0; oidx = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 40 && oidx < 4; cyc++) begin
            Data_out_ready = (cyc >= 5);
            if (idx < 4) begin
                Data_in_valid = 1'b1;
                Data_in       = bp_in[idx][7:0];
            end else begin
                Data_in_valid = 1'b0;
            end
            #1;
            acc = Data_in_valid && Data_in_ready;
            if (cyc >= 2 && cyc < 5) begin
                check("bp_stable", {16'd0, Data_out}, 32'd1);
            end
            if (cyc == 4) begin
                check("bp_accepted", idx, 2);
                check("bp_in_ready_low", {31'd0, Data_in_ready}, 32'd0);
            end
            if (Data_out_valid && Data_out_ready) begin
                check("bp_order", {16'd0, Data_out}, {16'd0, bp_in[oidx]});
                if (oidx == 0) first_cyc = cyc;
                last_cyc = cyc;
                oidx++;
            end
            step();
            if (acc) idx++;
        end
        Data_in_valid  = 1'b0;
        Data_out_ready = 1'b1;
        check("bp_all_out", oidx, 4);
        check("bp_one_per_cycle", last_cyc - first_cyc, 3);
        step();

        // Reset mid-op: two samples in flight with scale 2.0 loaded
        load_cfg(16'h0100, 16'h0000);
        Data_out_ready = 1'b0;
        Data_in_valid  = 1'b1; Data_in = 8'h11;
        step();
        Data_in = 8'h22;
        step();
        Data_in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        Data_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_no_out", {31'd0, Data_out_valid}, 32'd0);
            step();
        end
        check("rst_mid_count", {16'd0, sample_count}, 32'd0);
        send_check("rst_mid_scale1", 8'h05, 16'h0005, 1'b0);
        check("rst_mid_count_after", {16'd0, sample_count}, 32'd1);

        // Config hazard: load on the accept cycle, sample keeps old scale
        Data_in_valid = 1'b1; Data_in = 8'h03;
        cfg_load = 1'b1; cfg_scale = 16'h0100; cfg_bias = 16'h0000;
        step();
        cfg_load = 1'b0;
        step();
        Data_in_valid = 1'b0;
        check("hazard_old_scale", {16'd0, Data_out}, 32'h00000003);
        step();
        check("hazard_new_scale", {16'd0, Data_out}, 32'h00000006);
        check("hazard_valid", {31'd0, Data_out_valid}, 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
